// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared widths, wait-counter size and FSM state encoding for the SRAM arbiter.
package sram_arbiter_pkg;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
endpackage

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: two-way round-robin arbiter with a last-grant pointer.
module sram_rr_arb (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_b;
    always_comb grant = (req == 2'b11) ? (last_b ? 2'b01 : 2'b10) : req;
    // last_b starts high so that A wins the first contention after reset
    always_ff @(posedge clk_in)
        if (!rst_n) last_b <= 1'b1;
        else if (accept && |req) last_b <= grant[1];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between ports A and B with a fully registered
// CE/OE/WE sequence (SETUP, WAIT_CYCLES strobe, HOLD).
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_o,
    output logic              sram_data_oe,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic              sram_cen,
    output logic              sram_oen,
    output logic              sram_wen
);
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             idle, strobe_end, owner_b, wr;

    assign idle       = state == ST_IDLE;
    assign strobe_end = state == ST_STROBE && cnt == '0;
    assign a_gnt      = idle && rst_n && grant[0];
    assign b_gnt      = idle && rst_n && grant[1];

    sram_rr_arb u_arb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .req    ({b_req, a_req}),
        .accept (idle),
        .grant  (grant)
    );

    always_ff @(posedge clk_in)
        if (!rst_n) state <= ST_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = |grant ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: state_next = strobe_end ? ST_HOLD : ST_STROBE;
            ST_HOLD:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sram_cen     <= 1'b1;
            sram_oen     <= 1'b1;
            sram_wen     <= 1'b1;
            sram_data_oe <= 1'b0;
            sram_addr    <= '0;
            sram_data_o  <= '0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
            cnt          <= '0;
            owner_b      <= 1'b0;
            wr           <= 1'b0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                ST_IDLE: if (|grant) begin
                    sram_cen     <= 1'b0;
                    sram_addr    <= grant[0] ? a_addr : b_addr;
                    sram_data_o  <= grant[0] ? a_wdata : b_wdata;
                    sram_data_oe <= grant[0] ? a_we : b_we;
                    wr           <= grant[0] ? a_we : b_we;
                    owner_b      <= grant[1];
                end
                ST_SETUP: begin
                    sram_oen <= wr;
                    sram_wen <= !wr;
                    cnt      <= CNT_W'(WAIT_CYCLES - 1);
                end
                // read data is captured on the edge that ends the strobe, while OE is still low
                ST_STROBE: if (strobe_end) begin
                    sram_oen <= 1'b1;
                    sram_wen <= 1'b1;
                    a_done   <= !owner_b;
                    b_done   <= owner_b;
                    if (!wr && !owner_b) a_rdata <= sram_data_i;
                    if (!wr && owner_b) b_rdata <= sram_data_i;
                end else cnt <= cnt - 1'b1;
                ST_HOLD: begin
                    sram_cen     <= 1'b1;
                    sram_data_oe <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
